// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with req/ack memory port, small FIFO, redirect and HALT handling.
// Optional macro FETCH_BYPASS_EN forwards an ack word straight to decode when the FIFO is empty.
module fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] instruction,
    output logic [15:0] pc_plus2,
    output logic        inst_valid,
    output logic        halted
);
    localparam int AW = $clog2(BUF_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DROP, S_STOP, S_HALTED} state_t;

    state_t          r_state, w_state_n;
    logic [15:0]     r_pc, w_pc_n, r_addr, w_addr_n, w_pc2;
    logic [15:0]     r_word [BUF_DEPTH];
    logic [15:0]     r_pcp2 [BUF_DEPTH];
    logic [AW-1:0]   r_rd, r_wr;
    logic [CW-1:0]   r_count, w_count_n;
    logic            w_fifo_valid, w_ack, w_byp, w_byp_take, w_pop, w_push, w_redir, w_halt_take;

    assign w_pc2        = r_pc + 16'd2;
    assign w_fifo_valid = (r_count != '0) && (r_state != S_HALTED);
    assign w_ack        = (r_state == S_WAIT) && imem_ack;
    assign w_redir      = redirect && (r_state != S_HALTED);
`ifdef FETCH_BYPASS_EN
    assign w_byp        = w_ack && (r_count == '0) && !redirect;
`else
    assign w_byp        = 1'b0;
`endif
    assign w_byp_take   = w_byp && !stall;
    assign w_pop        = w_fifo_valid && !stall;
    assign w_push       = w_ack && !redirect && !w_byp_take;
    assign w_halt_take  = !w_redir && ((w_pop && r_word[r_rd][15:12] == 4'hF) ||
                                       (w_byp_take && imem_rdata[15:12] == 4'hF));
    assign w_count_n    = w_redir ? '0 : r_count + CW'(w_push) - CW'(w_pop);

    assign imem_req     = (r_state == S_WAIT) || (r_state == S_DROP);
    assign imem_addr    = r_addr;
    assign inst_valid   = w_fifo_valid || w_byp;
    assign instruction  = w_fifo_valid ? r_word[r_rd] : (w_byp ? imem_rdata : 16'h0000);
    assign pc_plus2     = w_fifo_valid ? r_pcp2[r_rd] : (w_byp ? w_pc2 : 16'h0000);
    assign halted       = (r_state == S_HALTED);

    // Next fetch state, PC and request address; redirect overrides everything but HALTED
    always_comb begin
        w_state_n = r_state;
        w_pc_n    = r_pc;
        w_addr_n  = r_addr;
        if (w_redir) begin
            w_pc_n = redirect_pc;
            if (r_state == S_DROP || (r_state == S_WAIT && !imem_ack)) begin
                w_state_n = S_DROP;
            end else begin
                w_state_n = S_WAIT;
                w_addr_n  = redirect_pc;
            end
        end else if (w_halt_take) begin
            w_state_n = S_HALTED;
        end else if (r_state == S_IDLE && r_count < DEPTH_C) begin
            w_state_n = S_WAIT;
            w_addr_n  = r_pc;
        end else if (w_ack) begin
            w_pc_n    = w_pc2;
            w_addr_n  = w_pc2;
            w_state_n = (imem_rdata[15:12] == 4'hF) ? S_STOP : (w_count_n < DEPTH_C ? S_WAIT : S_IDLE);
        end else if (r_state == S_DROP && imem_ack) begin
            w_state_n = S_WAIT;
            w_addr_n  = r_pc;
        end
    end

    // Control registers and FIFO pointers; a redirect flushes by zeroing the pointers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_addr  <= RESET_PC;
            r_count <= '0;
            r_rd    <= '0;
            r_wr    <= '0;
        end else begin
            r_state <= w_state_n;
            r_pc    <= w_pc_n;
            r_addr  <= w_addr_n;
            r_count <= w_count_n;
            r_rd    <= w_redir ? '0 : r_rd + AW'(w_pop);
            r_wr    <= w_redir ? '0 : r_wr + AW'(w_push);
        end
    end

    // FIFO storage; contents are only visible while the count is non-zero
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_word[r_wr] <= imem_rdata;
            r_pcp2[r_wr] <= w_pc2;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit with a latency-configurable memory model.
module tb_fetch_unit;
    logic        clk = 1'b0, rst = 1'b0;
    logic        imem_req, imem_ack, stall = 1'b0, redirect = 1'b0;
    logic [15:0] imem_addr, imem_rdata, redirect_pc = 16'h0000;
    logic [15:0] instruction, pc_plus2;
    logic        inst_valid, halted;
    int          lat = 0, wcnt, n_cmp = 0, n_bad = 0;
    logic [15:0] halt_addr = 16'h0001;

    typedef struct {
        logic        stall;
        logic        req;
        logic [15:0] addr;
        logic        valid;
        logic [15:0] inst;
        logic [15:0] pc2;
    } vec_t;
    vec_t vt [14];

    fetch_unit dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
        .redirect(redirect), .redirect_pc(redirect_pc), .instruction(instruction),
        .pc_plus2(pc_plus2), .inst_valid(inst_valid), .halted(halted)
    );

    always #5 clk = ~clk;

    // Memory returns 16'h1000+addr, or HALT at halt_addr, after lat wait cycles
    always_comb begin
        imem_ack   = imem_req && (wcnt >= lat);
        imem_rdata = (imem_addr == halt_addr) ? 16'hF000 : 16'h1000 + imem_addr;
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) wcnt <= 0;
        else if (imem_req) wcnt <= imem_ack ? 0 : wcnt + 1;
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_reset;
        rst = 1'b0;
        #1;
        chk("reset_outs", {imem_req, imem_addr, inst_valid, instruction, pc_plus2, halted}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        bit found, saw8;
        vt[0]  = '{1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000};
        vt[1]  = '{1'b0, 1'b1, 16'h0002, 1'b1, 16'h1000, 16'h0002};
        vt[2]  = '{1'b0, 1'b1, 16'h0004, 1'b1, 16'h1002, 16'h0004};
        vt[3]  = '{1'b0, 1'b1, 16'h0006, 1'b1, 16'h1004, 16'h0006};
        vt[4]  = '{1'b0, 1'b1, 16'h0008, 1'b1, 16'h1006, 16'h0008};
        for (int i = 5; i < 10; i++) vt[i] = '{1'b1, 1'b0, 16'h000A, 1'b1, 16'h1006, 16'h0008};
        vt[10] = '{1'b0, 1'b0, 16'h000A, 1'b1, 16'h1008, 16'h000A};
        vt[11] = '{1'b0, 1'b1, 16'h000A, 1'b0, 16'h0000, 16'h0000};
        vt[12] = '{1'b0, 1'b1, 16'h000C, 1'b1, 16'h100A, 16'h000C};
        vt[13] = '{1'b0, 1'b1, 16'h000E, 1'b1, 16'h100C, 16'h000E};

        // Zero-wait streaming, then stall with a full FIFO and release
        do_reset();
        for (int i = 0; i < 14; i++) begin
            stall = vt[i].stall;
            step();
            chk($sformatf("vec%0d", i), {imem_req, imem_addr, inst_valid, instruction, pc_plus2},
                {vt[i].req, vt[i].addr, vt[i].valid, vt[i].inst, vt[i].pc2});
        end

        // Slow memory, redirect during the second wait cycle
        stall = 1'b0;
        lat = 3;
        do_reset();
        step();
        chk("slow_req", {imem_req, imem_addr}, {1'b1, 16'h0000});
        step();
        redirect = 1'b1;
        redirect_pc = 16'h0040;
        step();
        redirect = 1'b0;
        chk("drop_hold", {imem_req, imem_addr, inst_valid}, {1'b1, 16'h0000, 1'b0});
        step();
        chk("drop_ack", {imem_req, imem_addr, inst_valid}, {1'b1, 16'h0000, 1'b0});
        step();
        chk("drop_to_wait", {imem_req, imem_addr, inst_valid}, {1'b1, 16'h0040, 1'b0});
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            found = inst_valid;
        end
        chk("redir_found", {63'd0, found}, 64'd1);
        chk("redir_first", {instruction, pc_plus2}, {16'h1040, 16'h0042});

        // HALT at 0x0006: no fetch of 0x0008, sticky halted
        lat = 0;
        halt_addr = 16'h0006;
        do_reset();
        found = 0;
        saw8 = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (imem_req && imem_addr == 16'h0008) saw8 = 1;
            found = inst_valid && instruction == 16'hF000;
        end
        chk("halt_found", {63'd0, found}, 64'd1);
        chk("halt_noreq", {63'd0, imem_req}, 64'd0);
        step();
        chk("halted_set", {halted, inst_valid, imem_req}, 3'b100);
        redirect = 1'b1;
        redirect_pc = 16'h0020;
        step();
        redirect = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("halted_sticky", {halted, inst_valid, imem_req}, 3'b100);
            if (imem_req && imem_addr == 16'h0008) saw8 = 1;
            step();
        end
        chk("no_fetch_0008", {63'd0, saw8}, 64'd0);

        // HALT buffered behind a stall, then flushed by redirect
        halt_addr = 16'h0002;
        stall = 1'b1;
        do_reset();
        step();
        step();
        step();
        chk("halt_buffered", {imem_req, inst_valid, instruction}, {1'b0, 1'b1, 16'h1000});
        redirect = 1'b1;
        redirect_pc = 16'h0010;
        step();
        redirect = 1'b0;
        stall = 1'b0;
        chk("halt_flushed", {imem_req, imem_addr, inst_valid, halted}, {1'b1, 16'h0010, 1'b0, 1'b0});
        step();
        chk("resume_0010", {inst_valid, instruction, pc_plus2, halted}, {1'b1, 16'h1010, 16'h0012, 1'b0});

        // Redirect with same-cycle ack to 0xFFFE, PC wraps to 0x0000
        redirect = 1'b1;
        redirect_pc = 16'hFFFE;
        step();
        redirect = 1'b0;
        chk("wrap_req", {imem_req, imem_addr, inst_valid}, {1'b1, 16'hFFFE, 1'b0});
        step();
        chk("wrap_next", {imem_req, imem_addr, inst_valid, instruction, pc_plus2},
            {1'b1, 16'h0000, 1'b1, 16'h0FFE, 16'h0000});

        // Asynchronous reset in the middle of a WAIT cycle
        lat = 3;
        step();
        #2;
        do_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
